// File: rtl/sram_march_bist_ctrl.sv
// March C- BIST sequencer for a single-port bit-masked SRAM; one op/cycle, 10*D ops, read compare lags the read by 2 edges.
// No backpressure: a run is free-running once started and only ABORT or reset stop it; START while busy is dropped.
module sram_march_bist_ctrl #(
    parameter int P_DATA_WIDTH = 64,
    parameter int P_ADDR_WIDTH = 8
) (
    input  logic                    A_CLK,
    input  logic                    A_RESET_N,
    input  logic                    START,
    input  logic                    ABORT,
    output logic                    BUSY,
    output logic                    DONE,
    output logic                    FAIL,
    output logic [P_ADDR_WIDTH-1:0] FAIL_ADDR,
    output logic [2:0]              FAIL_ELEM,
    output logic                    A_BIST_EN,
    output logic                    A_BIST_MEN,
    output logic                    A_BIST_WEN,
    output logic                    A_BIST_REN,
    output logic [P_ADDR_WIDTH-1:0] A_BIST_ADDR,
    output logic [P_DATA_WIDTH-1:0] A_BIST_DIN,
    output logic [P_DATA_WIDTH-1:0] A_BIST_BM,
    input  logic [P_DATA_WIDTH-1:0] A_DOUT
);

    localparam logic [P_ADDR_WIDTH-1:0] ADDR_MAX = '1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

    state_t                  state, state_nxt;
    logic [2:0]              elem, elem_nxt;
    logic [P_ADDR_WIDTH-1:0] addr, addr_nxt;
    logic                    ph, ph_nxt;

    logic                    two_op, down, last_op;
    logic [P_ADDR_WIDTH-1:0] end_addr;
    logic                    run_nxt, rd_nxt, wr_nxt, en_nxt, done_nxt;

    logic                    rd_p, exp_p;
    logic [P_ADDR_WIDTH-1:0] addr_p;
    logic [2:0]              elem_p;

    // E1..E4 are read-then-write per address; E3/E4 walk downwards.
    assign two_op   = (elem != 3'd0) && (elem != 3'd5);
    assign down     = (elem == 3'd3) || (elem == 3'd4);
    assign end_addr = down ? '0 : ADDR_MAX;
    assign last_op  = (elem == 3'd5) && (addr == ADDR_MAX);

    always_ff @(posedge A_CLK or negedge A_RESET_N) begin
        if (!A_RESET_N) begin
            state <= S_IDLE;
            elem  <= '0;
            addr  <= '0;
            ph    <= 1'b0;
        end else begin
            state <= state_nxt;
            elem  <= elem_nxt;
            addr  <= addr_nxt;
            ph    <= ph_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        elem_nxt  = elem;
        addr_nxt  = addr;
        ph_nxt    = ph;
        case (state)
            S_IDLE: begin
                if (START && !ABORT) begin
                    state_nxt = S_RUN;
                    elem_nxt  = '0;
                    addr_nxt  = '0;
                    ph_nxt    = 1'b0;
                end
            end
            S_RUN: begin
                if (ABORT) begin
                    state_nxt = S_IDLE;
                end else if (last_op) begin
                    state_nxt = S_DRAIN;
                end else if (two_op && !ph) begin
                    ph_nxt = 1'b1;
                end else begin
                    ph_nxt = 1'b0;
                    if (addr == end_addr) begin
                        elem_nxt = (elem == 3'd5) ? 3'd5 : elem + 3'd1;
                        addr_nxt = ((elem_nxt == 3'd3) || (elem_nxt == 3'd4)) ? ADDR_MAX : '0;
                    end else begin
                        addr_nxt = down ? addr - 1'b1 : addr + 1'b1;
                    end
                end
            end
            S_DRAIN: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Macro pins are registered from the next-op decode so op k appears right after edge k.
    always_comb begin
        run_nxt  = (state_nxt == S_RUN);
        rd_nxt   = run_nxt && (elem_nxt != 3'd0) && !ph_nxt;
        wr_nxt   = run_nxt && !rd_nxt;
        en_nxt   = (state_nxt != S_IDLE);
        done_nxt = (state == S_DRAIN) && !ABORT;
    end

    always_ff @(posedge A_CLK or negedge A_RESET_N) begin
        if (!A_RESET_N) begin
            BUSY        <= 1'b0;
            DONE        <= 1'b0;
            A_BIST_EN   <= 1'b0;
            A_BIST_MEN  <= 1'b0;
            A_BIST_WEN  <= 1'b0;
            A_BIST_REN  <= 1'b0;
            A_BIST_ADDR <= '0;
            A_BIST_DIN  <= '0;
            A_BIST_BM   <= '0;
        end else begin
            BUSY        <= en_nxt;
            DONE        <= done_nxt;
            A_BIST_EN   <= en_nxt;
            A_BIST_MEN  <= run_nxt;
            A_BIST_WEN  <= wr_nxt;
            A_BIST_REN  <= rd_nxt;
            A_BIST_ADDR <= run_nxt ? addr_nxt : '0;
            A_BIST_DIN  <= wr_nxt ? {P_DATA_WIDTH{elem_nxt[0]}} : '0;
            A_BIST_BM   <= run_nxt ? {P_DATA_WIDTH{1'b1}} : '0;
        end
    end

    // Odd elements write ones and read zeros; even elements the reverse.
    always_ff @(posedge A_CLK or negedge A_RESET_N) begin
        if (!A_RESET_N) begin
            rd_p      <= 1'b0;
            exp_p     <= 1'b0;
            addr_p    <= '0;
            elem_p    <= '0;
            FAIL      <= 1'b0;
            FAIL_ADDR <= '0;
            FAIL_ELEM <= '0;
        end else begin
            rd_p   <= A_BIST_REN && !ABORT;
            exp_p  <= ~elem[0];
            addr_p <= addr;
            elem_p <= elem;
            if ((state == S_IDLE) && START && !ABORT) begin
                FAIL      <= 1'b0;
                FAIL_ADDR <= '0;
                FAIL_ELEM <= '0;
            end else if (rd_p && !ABORT && !FAIL && (A_DOUT != {P_DATA_WIDTH{exp_p}})) begin
                FAIL      <= 1'b1;
                FAIL_ADDR <= addr_p;
                FAIL_ELEM <= elem_p;
            end
        end
    end

endmodule

// File: doc/sram_march_bist_ctrl.md
Name: sram_march_bist_ctrl

Overview:
- March C- built-in self-test sequencer for the single-port byte/bit-masked SRAM macros, e.g. the 256x64 c2 bm_bist instance.
- Drives the macro's A_BIST_* port and takes the array over via A_BIST_EN for the duration of a run.
- Compares A_DOUT against the expected pattern and reports pass/fail with the first failing address and march element.
- Sits beside each macro and is started by the chip test controller.

Parameters:
- P_DATA_WIDTH, 64, SRAM word width.
- P_ADDR_WIDTH, 8, SRAM address width; depth D = 2^P_ADDR_WIDTH.

Ports:
- A_CLK  input  1  clock; also drives the macro's A_BIST_CLK.
- A_RESET_N  input  1  reset, asynchronous, active-low.
- START  input  1  single-cycle request; accepted only in IDLE.
- ABORT  input  1  synchronous abort; returns to IDLE.
- BUSY  output  1  high while a run is active (RUN or DRAIN).
- DONE  output  1  one-cycle pulse at normal completion.
- FAIL  output  1  sticky mismatch flag; valid from DONE until the next START.
- FAIL_ADDR  output  P_ADDR_WIDTH  address of the first mismatch.
- FAIL_ELEM  output  3  march element index (0-5) of the first mismatch.
- A_BIST_EN  output  1  macro BIST port select.
- A_BIST_MEN  output  1  macro enable.
- A_BIST_WEN  output  1  write enable.
- A_BIST_REN  output  1  read enable.
- A_BIST_ADDR  output  P_ADDR_WIDTH  address.
- A_BIST_DIN  output  P_DATA_WIDTH  write data.
- A_BIST_BM  output  P_DATA_WIDTH  bit mask; all ones whenever MEN=1, else 0.
- A_DOUT  input  P_DATA_WIDTH  macro read data, valid the cycle after the read edge.

Behaviour:
- Reset (async, A_RESET_N=0): state=IDLE. All outputs are 0, including FAIL, FAIL_ADDR, FAIL_ELEM and A_BIST_EN. Any run in progress is discarded.
- Registered outputs: every macro-facing output is a flop.
- States and transitions:
  - IDLE -> RUN on START.
  - RUN -> DRAIN after the last op.
  - DRAIN -> IDLE after one cycle, with DONE pulsed.
- March sequence, fixed, with data backgrounds 0 = all zeros and 1 = all ones:
  - E0: up, (w0)
  - E1: up, (r0, w1)
  - E2: up, (r1, w0)
  - E3: down, (r0, w1)
  - E4: down, (r1, w0)
  - E5: up, (r0)
- Addressing: up runs 0..D-1; down runs D-1..0. Within a two-op element, both ops target the same address on consecutive cycles, read first.
- Operation count: N = 10*D ops. N = 2560 for the defaults.
- Op timing:
  - One op per cycle, with no idle cycles between elements.
  - On a read op: MEN=1, REN=1, WEN=0.
  - On a write op: MEN=1, WEN=1, REN=0.
  - WEN and REN are never both 1.
- Start timing: START is sampled at edge 0; FAIL, FAIL_ADDR and FAIL_ELEM clear at that edge. Op k is presented after edge k and sampled by the macro at edge k+1, for k = 0..N-1.
- Compare:
  - Each read's expected value and its address/element are pipelined one stage.
  - A_DOUT is compared at the edge after the macro samples the read.
  - The first mismatch sets FAIL and captures FAIL_ADDR/FAIL_ELEM. Later mismatches do not overwrite the capture.
  - The run always continues to completion.
- DRAIN:
  - After edge N: MEN, WEN and REN are 0, A_BIST_EN stays 1, and the final read is compared.
  - DONE=1 for exactly one cycle after edge N+1. BUSY and A_BIST_EN fall at the same edge.
- BUSY: 1 after edge 0 through edge N+1.
- START while BUSY: ignored. START together with ABORT in IDLE: ABORT wins and the start is ignored.
- ABORT in RUN/DRAIN:
  - Next edge goes to IDLE with all macro outputs 0.
  - No DONE pulse.
  - FAIL fields hold their current values, i.e. not valid.
- Counters: the address counter wraps at D boundaries only at element transitions and never exceeds the range. The element counter saturates at 5.

Test Plan:
- Healthy memory model (behavioural SRAM), START at cycle 0 -> BUSY high for 2561 cycles, DONE pulse after edge 2561, FAIL=0; the write count to each address is exactly 5.
- Bench forces A_DOUT[17] to 1 on the E1 read of address 0x3C -> FAIL=1, FAIL_ADDR=0x3C, FAIL_ELEM=1, DONE still at edge 2561.
- Two injected faults: E3 at address 0xFF, then E5 at address 0x00 -> FAIL_ADDR=0xFF, FAIL_ELEM=3 (first mismatch retained).
- Protocol monitor over a full run -> never WEN&REN; A_BIST_BM=all ones iff MEN; E3 starts at address 0xFF and decrements; A_BIST_EN=0 in IDLE.
- ABORT at cycle 1000, then A_RESET_N low at cycle 40 of a new run -> immediate IDLE with all outputs 0, no DONE; the next START completes normally.
- START re-asserted at cycle 500 of a run -> ignored, DONE still at edge 2561.
